bypass_subtractor_seq: RTL

- Block-serial borrow-skip subtractor. Computes Diff = A - B - Bin one K-bit block per cycle, LSB block first, with a valid/ready handshake on both sides.
- Counterpart of the combinational carry-skip adder. It sits in the datapath where subtraction and compare results can tolerate multi-cycle latency in exchange for a single K-bit slice of hardware.
- Subtraction is implemented as A + ~B + ~Bin. Borrow out equals the inverted final carry.

---
 rtl/bypass_sub_pkg.sv | 18 +
 rtl/skip_sub_block.sv | 24 ++
 rtl/bypass_subtractor_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/bypass_sub_pkg.sv
// rtl/bypass_sub_pkg.sv - shared constants, state encoding and helpers for bypass_subtractor_seq
package bypass_sub_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_K = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of K-bit slices needed to cover an n-bit operand.
  function automatic int num_blocks(input int n, input int k);
    return n / k;
  endfunction

endpackage

// File: rtl/skip_sub_block.sv
// rtl/skip_sub_block.sv - one K-bit slice of A + ~B + carry with a borrow-skip mux
module skip_sub_block #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] nb,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         p
);

  logic [K:0] sum;

  // Ripple sum of the slice; when every bit propagates, the incoming carry is
  // forwarded directly, which is exactly what the ripple would produce anyway.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, nb} + {{K{1'b0}}, cin};
    s    = sum[K-1:0];
    p    = &(a ^ nb);
    cout = p ? cin : sum[K];
  end

endmodule

// File: rtl/bypass_subtractor_seq.sv
// rtl/bypass_subtractor_seq.sv - block-serial A - B - Bin with valid/ready on both sides
module bypass_subtractor_seq
  import bypass_sub_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         Ovf
);

  localparam int NUM_BLOCKS = num_blocks(N, K);
  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  if ((N % K) != 0) begin : g_bad_width
    $error("bypass_subtractor_seq: N must be a multiple of K");
  end

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  nb_sh;
  logic          carry;
  logic          a_sign;
  logic          b_sign;

  logic [K-1:0]  blk_s;
  logic          blk_cout;
  logic          blk_p;
  logic          unused_blk_p;

  // Operands are shifted right each RUN cycle so the active slice is always
  // the low K bits; this is equivalent to selecting slice idx of the latched
  // operands without a wide variable-index mux.
  skip_sub_block #(.K(K)) u_blk (
    .a    (a_sh[K-1:0]),
    .nb   (nb_sh[K-1:0]),
    .cin  (carry),
    .s    (blk_s),
    .cout (blk_cout),
    .p    (blk_p)
  );

  // Slice propagate is only of interest inside the slice's skip mux.
  assign unused_blk_p = blk_p;

  // Handshake flags follow directly from the state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // FSM, operand latch, slice sequencing and result registers.
  // Diff is filled from the top: after NUM_BLOCKS shifts slice 0 lands in the
  // low bits and the last slice computed occupies the sign position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_sh   <= '0;
      nb_sh  <= '0;
      carry  <= 1'b0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= A;
            nb_sh  <= ~B;
            carry  <= ~Bin;
            a_sign <= A[N-1];
            b_sign <= B[N-1];
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> K;
          nb_sh <= nb_sh >> K;
          carry <= blk_cout;
          Diff  <= (Diff >> K) | (N'(blk_s) << (N - K));
          if (idx == LAST_IDX) begin
            Bout  <= ~blk_cout;
            Ovf   <= (a_sign != b_sign) && (blk_s[K-1] != a_sign);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
